sobel_edge_pipeline: RTL

//  Consumes the 3x3 4-bit pixel windows produced by the SPI pixel-window front end
//  and computes a Sobel gradient magnitude per window in a 3-stage valid-tagged pipeline.

---
 rtl/edge_pkg.sv | 17 +
 rtl/sobel_kernel.sv | 24 ++
 rtl/sobel_edge_pipeline.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and image geometry for the Sobel edge pipeline.
package edge_pkg;

    localparam int unsigned IMG_W = 320;
    localparam int unsigned IMG_H = 240;

    typedef logic [3:0] pixel_t;
    typedef pixel_t window_t [3][3];

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [8:0] y;
        logic       border;
    } pix_tag_t;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel operator: signed horizontal and vertical gradients.
module sobel_kernel
    import edge_pkg::*;
(
    input  window_t           win,
    output logic signed [6:0] gx,
    output logic signed [6:0] gy
);

    logic [6:0] gxPos;
    logic [6:0] gxNeg;
    logic [6:0] gyPos;
    logic [6:0] gyNeg;

    always_comb begin
        gxPos = 7'(win[0][2]) + 7'({win[1][2], 1'b0}) + 7'(win[2][2]);
        gxNeg = 7'(win[0][0]) + 7'({win[1][0], 1'b0}) + 7'(win[2][0]);
        gyPos = 7'(win[2][0]) + 7'({win[2][1], 1'b0}) + 7'(win[2][2]);
        gyNeg = 7'(win[0][0]) + 7'({win[0][1], 1'b0}) + 7'(win[0][2]);
        gx    = $signed(gxPos - gxNeg);
        gy    = $signed(gyPos - gyNeg);
    end

endmodule

// File: rtl/sobel_edge_pipeline.sv
// Three-stage Sobel pipeline (gradients, magnitude, saturate/threshold) with a
// frame-start shadowed threshold and a per-frame edge-pixel counter.
module sobel_edge_pipeline
    import edge_pkg::*;
#(
    parameter int unsigned IMG_W     = edge_pkg::IMG_W,
    parameter int unsigned IMG_H     = edge_pkg::IMG_H,
    parameter int unsigned MAG_SHIFT = 2
) (
    input  logic        mainClk,
    input  logic        reset,
    input  logic [3:0]  winIn [3][3],
    input  logic        winValid,
    input  logic [9:0]  xIn,
    input  logic [8:0]  yIn,
    input  logic [6:0]  threshold,
    output logic [3:0]  edgeMag,
    output logic        edgeBit,
    output logic [9:0]  edgeX,
    output logic [8:0]  edgeY,
    output logic        edgeValid,
    output logic        frameDone,
    output logic [16:0] edgeCount
);

    localparam logic [16:0] COUNT_MAX = '1;

    logic signed [6:0] kGx;
    logic signed [6:0] kGy;
    logic              firstWin;
    logic              inBorder;
    logic [9:0]        centreX;
    logic [6:0]        shadowThr;

    pix_tag_t          s1Tag;
    logic signed [6:0] s1Gx;
    logic signed [6:0] s1Gy;
    logic [6:0]        s1Thr;

    pix_tag_t          s2Tag;
    logic [6:0]        s2Mag;
    logic [6:0]        s2Thr;

    logic [6:0]        absGx;
    logic [6:0]        absGy;
    logic [6:0]        magShifted;
    logic [3:0]        magSat;
    logic              hit;
    logic              lastWin;
    logic [16:0]       running;
    logic [16:0]       runNext;

    sobel_kernel u_kernel (
        .win (winIn),
        .gx  (kGx),
        .gy  (kGy)
    );

    always_comb begin
        firstWin = winValid && (xIn == '0) && (yIn == '0);
        inBorder = (xIn < 10'd2) || (yIn == '0) || (yIn == 9'(IMG_H - 1));
        centreX  = (xIn == '0) ? '0 : xIn - 10'd1;
    end

    // Stage 1: gradients, tag and the threshold this window will be judged against
    always_ff @(posedge mainClk) begin
        if (reset) begin
            shadowThr <= '0;
            s1Tag     <= '0;
            s1Gx      <= '0;
            s1Gy      <= '0;
            s1Thr     <= '0;
        end else begin
            if (firstWin)
                shadowThr <= threshold;
            if (winValid) begin
                s1Tag <= '{valid: 1'b1, x: centreX, y: yIn, border: inBorder};
                s1Gx  <= kGx;
                s1Gy  <= kGy;
                // Threshold travels with the window so a new frame cannot retarget older ones
                s1Thr <= firstWin ? threshold : shadowThr;
            end else begin
                s1Tag.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        absGx = s1Gx[6] ? 7'(-s1Gx) : 7'(s1Gx);
        absGy = s1Gy[6] ? 7'(-s1Gy) : 7'(s1Gy);
    end

    // Stage 2: L1 gradient magnitude
    always_ff @(posedge mainClk) begin
        if (reset) begin
            s2Tag <= '0;
            s2Mag <= '0;
            s2Thr <= '0;
        end else begin
            if (s1Tag.valid) begin
                s2Tag <= s1Tag;
                s2Mag <= absGx + absGy;
                s2Thr <= s1Thr;
            end else begin
                s2Tag.valid <= 1'b0;
            end
        end
    end

    always_comb begin
        magShifted = s2Mag >> MAG_SHIFT;
        magSat     = (magShifted > 7'd15) ? 4'd15 : magShifted[3:0];
        hit        = !s2Tag.border && (s2Mag >= s2Thr);
        lastWin    = (s2Tag.x == 10'(IMG_W - 2)) && (s2Tag.y == 9'(IMG_H - 1));
        runNext    = (hit && (running != COUNT_MAX)) ? running + 17'd1 : running;
    end

    // Stage 3: registered outputs and frame accounting
    always_ff @(posedge mainClk) begin
        if (reset) begin
            edgeMag   <= '0;
            edgeBit   <= 1'b0;
            edgeX     <= '0;
            edgeY     <= '0;
            edgeValid <= 1'b0;
            frameDone <= 1'b0;
            edgeCount <= '0;
            running   <= '0;
        end else begin
            edgeValid <= s2Tag.valid;
            frameDone <= s2Tag.valid && lastWin;
            if (s2Tag.valid) begin
                edgeMag <= s2Tag.border ? 4'd0 : magSat;
                edgeBit <= hit;
                edgeX   <= s2Tag.x;
                edgeY   <= s2Tag.y;
                if (lastWin) begin
                    edgeCount <= runNext;
                    running   <= '0;
                end else begin
                    running <= runNext;
                end
            end
        end
    end

endmodule
